// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency
// and requests pipeline stalls while a long operation is in flight.
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_type,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        cancel,
    input  logic        d_mdu_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;

    logic        accept;
    logic        is_mult, is_multu, is_div, is_divu;
    logic        is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic        is_long;

    assign is_mult  = (mdu_type == 4'd1);
    assign is_multu = (mdu_type == 4'd2);
    assign is_div   = (mdu_type == 4'd3);
    assign is_divu  = (mdu_type == 4'd4);
    assign is_mfhi  = (mdu_type == 4'd5);
    assign is_mflo  = (mdu_type == 4'd6);
    assign is_mthi  = (mdu_type == 4'd7);
    assign is_mtlo  = (mdu_type == 4'd8);
    assign is_long  = is_mult | is_multu | is_div | is_divu;

    assign accept = start & ~cancel & ~busy;

    // Released in the last busy cycle so the waiting op meets fresh HI/LO.
    assign stall = d_mdu_use &
                   ((busy & (cnt != 4'd1)) | (accept & is_long));

    assign rd_data = is_mfhi ? hi : (is_mflo ? lo : 32'd0);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a, abs_b, sdiv_b, udiv_b;
    logic [31:0] q_mag, r_mag, uq, ur;

    assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    assign prod_u = {32'd0, op_a} * {32'd0, op_b};

    // Signed divide on magnitudes avoids the MIN/-1 overflow corner.
    assign abs_a  = op_a[31] ? (~op_a + 32'd1) : op_a;
    assign abs_b  = op_b[31] ? (~op_b + 32'd1) : op_b;
    assign sdiv_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign udiv_b = (op_b == 32'd0) ? 32'd1 : op_b;
    assign q_mag  = abs_a / sdiv_b;
    assign r_mag  = abs_a % sdiv_b;
    assign uq     = op_a / udiv_b;
    assign ur     = op_a % udiv_b;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        unique case (1'b1)
            is_mult: begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            is_multu: begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            is_div: begin
                res_lo = (op_a[31] ^ op_b[31]) ? (~q_mag + 32'd1) : q_mag;
                res_hi = op_a[31] ? (~r_mag + 32'd1) : r_mag;
                res_wr = (op_b != 32'd0);
            end
            is_divu: begin
                res_lo = uq;
                res_hi = ur;
                res_wr = (op_b != 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_long) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_wr <= res_wr;
                            cnt     <= (is_mult | is_multu) ? MULT_N : DIV_N;
                            busy    <= 1'b1;
                            state   <= BUSY;
                        end else if (is_mthi) begin
                            hi <= op_a;
                        end else if (is_mtlo) begin
                            lo <= op_a;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        cnt   <= 4'd0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: vector table, hand-built corner sequences and
// random traffic checked against a cycle-level behavioural model.
module tb_mdu_sequencer;

    localparam int MN = 5;
    localparam int DN = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_type;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cancel;
    logic        d_mdu_use;
    logic        busy;
    logic        stall;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_sequencer #(.MULT_CYCLES(MN), .DIV_CYCLES(DN)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mdu_type(mdu_type),
        .op_a(op_a),
        .op_b(op_b),
        .cancel(cancel),
        .d_mdu_use(d_mdu_use),
        .busy(busy),
        .stall(stall),
        .rd_data(rd_data),
        .hi(hi),
        .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: architectural regs, pending result, busy cycles left
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pwr;
    int          m_rem;

    logic        s_stall;
    logic [31:0] s_rd;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_rem = 0;
    endtask

    task automatic compute(input logic [3:0] ty, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] rh,
                           output logic [31:0] rl, output bit wr);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = 0; rl = 0; wr = 0;
        case (ty)
            4'd1: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; wr = 1; end
            4'd2: begin
                up = 64'(a) * 64'(b);
                rh = up[63:32]; rl = up[31:0]; wr = 1;
            end
            4'd3: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                rl = q[31:0]; rh = r[31:0]; wr = 1;
            end
            4'd4: if (b != 0) begin rl = a / b; rh = a % b; wr = 1; end
            default: ;
        endcase
    endtask

    task automatic cycle(input bit st, input logic [3:0] ty,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit cn, input bit du);
        bit acc, lng;
        logic [31:0] exp_rd;
        start = st; mdu_type = ty; op_a = a; op_b = b;
        cancel = cn; d_mdu_use = du;
        #1;
        lng = (ty >= 4'd1) && (ty <= 4'd4);
        acc = st && !cn && (m_rem == 0);
        exp_rd = (ty == 4'd5) ? m_hi : ((ty == 4'd6) ? m_lo : 32'd0);
        s_stall = stall;
        s_rd = rd_data;
        chk("stall", {31'd0, stall}, {31'd0, du && ((m_rem > 1) || (acc && lng))});
        chk("rd_data", rd_data, exp_rd);
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (acc) begin
            if (lng) begin
                compute(ty, a, b, m_phi, m_plo, m_pwr);
                m_rem = (ty <= 4'd2) ? MN : DN;
            end else if (ty == 4'd7) m_hi = a;
            else if (ty == 4'd8) m_lo = a;
        end
        @(posedge clk);
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic idle(input bit du);
        cycle(0, 4'd0, 0, 0, 0, du);
    endtask

    task automatic drain(output int bc);
        bc = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            idle(0);
            bc++;
        end
    endtask

    typedef struct {
        logic [3:0]  ty;
        logic [31:0] a, b, pre_hi, pre_lo, e_hi, e_lo;
        int          n;
    } vec_t;

    vec_t tbl[8];
    int   bc;
    logic st_seq[6];
    logic any_st;

    initial begin
        tbl[0] = '{4'd1, 32'hFFFFFFFD, 32'd5, 32'h1, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFF1, MN};
        tbl[1] = '{4'd2, 32'hFFFFFFFD, 32'd5, 32'h3, 32'h4, 32'h00000004, 32'hFFFFFFF1, MN};
        tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'h5, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFFD, DN};
        tbl[3] = '{4'd4, 32'd7, 32'd2, 32'h7, 32'h8, 32'd1, 32'd3, DN};
        tbl[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h9, 32'hA, 32'd0, 32'h80000000, DN};
        tbl[5] = '{4'd4, 32'd1234, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, DN};
        tbl[6] = '{4'd1, 32'd6, 32'd7, 32'hB, 32'hC, 32'd0, 32'd42, MN};
        tbl[7] = '{4'd3, 32'd7, 32'hFFFFFFFE, 32'hD, 32'hE, 32'd1, 32'hFFFFFFFD, DN};

        model_reset();
        reset = 0; start = 0; mdu_type = 0; op_a = 0; op_b = 0;
        cancel = 0; d_mdu_use = 0;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1;
        idle(0);

        for (int i = 0; i < 8; i++) begin
            cycle(1, 4'd7, tbl[i].pre_hi, 0, 0, 0);
            cycle(1, 4'd8, tbl[i].pre_lo, 0, 0, 0);
            cycle(1, tbl[i].ty, tbl[i].a, tbl[i].b, 0, 0);
            drain(bc);
            chk("tbl_busy_len", 32'(bc), 32'(tbl[i].n));
            chk("tbl_hi", hi, tbl[i].e_hi);
            chk("tbl_lo", lo, tbl[i].e_lo);
        end

        // MTHI in idle: visible next edge, never busy
        cycle(1, 4'd7, 32'hABCD, 0, 0, 0);
        chk("mthi_hi", hi, 32'hABCD);
        chk("mthi_busy", {31'd0, busy}, 32'd0);

        // stall window with a D-stage MDU op waiting
        cycle(1, 4'd1, 32'd3, 32'd4, 0, 1);
        st_seq[0] = s_stall;
        for (int k = 1; k < 6; k++) begin
            idle(1);
            st_seq[k] = s_stall;
        end
        for (int k = 0; k < 6; k++)
            chk($sformatf("stall_seq%0d", k), {31'd0, st_seq[k]},
                {31'd0, k < 5});
        cycle(1, 4'd6, 0, 0, 0, 1);
        chk("mflo_prod", s_rd, 32'd12);
        cycle(1, 4'd5, 0, 0, 0, 1);
        chk("mfhi_prod", s_rd, 32'd0);

        any_st = 0;
        cycle(1, 4'd2, 32'd9, 32'd9, 0, 0);
        any_st |= s_stall;
        for (int k = 0; k < 6; k++) begin
            idle(0);
            any_st |= s_stall;
        end
        chk("no_duse_stall", {31'd0, any_st}, 32'd0);

        // cancelled start, then cancel pulsed mid-operation
        cycle(1, 4'd1, 32'h10000, 32'h10000, 1, 0);
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_lo", lo, 32'd81);
        cycle(1, 4'd1, 32'h10000, 32'h10000, 0, 0);
        idle(0);
        cycle(0, 4'd0, 0, 0, 1, 0);
        drain(bc);
        chk("cancel_mid_hi", hi, 32'd1);
        chk("cancel_mid_lo", lo, 32'd0);

        // asynchronous reset during a divide
        cycle(1, 4'd3, 32'd100, 32'd7, 0, 0);
        idle(0);
        idle(0);
        reset = 0;
        #1;
        model_reset();
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1;
        cycle(1, 4'd1, 32'd6, 32'd7, 0, 0);
        drain(bc);
        chk("post_rst_lo", lo, 32'd42);
        chk("post_rst_len", 32'(bc), 32'(MN));

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            if ($urandom_range(0, 7) == 0) b = 0;
            else if ($urandom_range(0, 1) == 1) b = $urandom;
            else b = $urandom_range(1, 20);
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 8)), a, b,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
